// File: rtl/mem_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : mem_scheduler
// Description : Three-requester round-robin scheduler with a single outstanding
//               downstream transaction and a response timeout.
// Revision    : 1.0 - initial release
// =============================================================================
module mem_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  s_valid,
    input  logic [95:0] s_addr,
    input  logic [95:0] s_wdata,
    input  logic [11:0] s_wstrb,
    output logic [2:0]  s_ready,
    output logic [31:0] s_rdata,
    output logic        s_error,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    input  logic        m_error
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_owner;
    logic [1:0]  r_last;
    logic [7:0]  r_cnt;
    logic [2:0]  r_pend;
    logic [31:0] r_addr  [3];
    logic [31:0] r_wdata [3];
    logic [3:0]  r_wstrb [3];

    logic        r_m_valid;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [3:0]  r_m_wstrb;

    logic        w_busy;
    logic        w_timeout;
    logic        w_resp;
    logic        w_arb_en;
    logic [2:0]  w_resp_mask;
    logic [2:0]  w_elig;
    logic [1:0]  w_start;
    logic [2:0]  w_sum;
    logic        w_grant;
    logic [1:0]  w_gidx;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wstrb;

    assign w_busy      = (r_state == BUSY);
    assign w_timeout   = w_busy && !m_ready && (r_cnt == C_TIMEOUT);
    assign w_resp      = !reset && w_busy && (m_ready || w_timeout);
    // The response cycle doubles as an arbitration cycle so back-to-back
    // transactions lose no bubble.
    assign w_arb_en    = !reset && (!w_busy || w_resp);
    assign w_resp_mask = w_resp ? (3'b001 << r_owner) : 3'b000;
    // The owner's re-request in its own response cycle only becomes pending.
    assign w_elig      = r_pend | (s_valid & ~w_resp_mask);

    always_comb begin
        w_start = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_sum   = 3'd0;
        w_grant = 1'b0;
        w_gidx  = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            w_sum = {1'b0, w_start} + 3'(k);
            if (w_sum >= 3'd3) begin
                w_sum = w_sum - 3'd3;
            end
            if (w_arb_en && w_elig[w_sum[1:0]]) begin
                w_grant = 1'b1;
                w_gidx  = w_sum[1:0];
            end
        end
    end

    assign w_sel_addr  = r_pend[w_gidx] ? r_addr[w_gidx]  : s_addr[{w_gidx, 5'b0} +: 32];
    assign w_sel_wdata = r_pend[w_gidx] ? r_wdata[w_gidx] : s_wdata[{w_gidx, 5'b0} +: 32];
    assign w_sel_wstrb = r_pend[w_gidx] ? r_wstrb[w_gidx] : s_wstrb[{w_gidx, 2'b0} +: 4];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 3'b000;
        s_rdata     = 32'd0;
        s_error     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_resp) begin
                    s_ready     = w_resp_mask;
                    s_rdata     = m_ready ? m_rdata : 32'd0;
                    s_error     = m_ready ? m_error : 1'b1;
                    w_state_nxt = w_grant ? BUSY : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend    <= 3'b000;
            r_cnt     <= 8'd0;
            r_last    <= 2'd2;
            r_owner   <= 2'd0;
            r_m_valid <= 1'b0;
            r_m_addr  <= 32'd0;
            r_m_wdata <= 32'd0;
            r_m_wstrb <= 4'd0;
        end else begin
            r_m_valid <= w_grant;
            r_m_addr  <= w_grant ? w_sel_addr  : 32'd0;
            r_m_wdata <= w_grant ? w_sel_wdata : 32'd0;
            r_m_wstrb <= w_grant ? w_sel_wstrb : 4'd0;
            if (w_grant) begin
                r_last  <= w_gidx;
                r_owner <= w_gidx;
                r_cnt   <= 8'd1;
            end else if (w_resp) begin
                r_cnt   <= 8'd0;
            end else if (w_busy) begin
                r_cnt   <= r_cnt + 8'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (w_grant && (w_gidx == 2'(i))) begin
                    r_pend[i] <= 1'b0;
                end else if (s_valid[i]) begin
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

    // A set pending flag protects the original request from being overwritten.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (s_valid[i] && !r_pend[i] && !(w_grant && (w_gidx == 2'(i)))) begin
                r_addr[i]  <= s_addr[32*i +: 32];
                r_wdata[i] <= s_wdata[32*i +: 32];
                r_wstrb[i] <= s_wstrb[4*i +: 4];
            end
        end
    end

    assign m_valid = r_m_valid && !reset;
    assign m_addr  = reset ? 32'd0 : r_m_addr;
    assign m_wdata = reset ? 32'd0 : r_m_wdata;
    assign m_wstrb = reset ? 4'd0  : r_m_wstrb;

endmodule
`default_nettype wire
